mmu_feeder_n: RTL and testbench
===============================

MMU_FEEDER_N -- requirements
Module: mmu_feeder_n

Interface
REQ-001 SHALL have parameter N, default 2, systolic array dimension (legal 2..8).
REQ-002 SHALL have parameter DW, default 8, operand and output width.
REQ-003 SHALL have parameter ACCW, default 16, accumulator width (ACCW > DW).
REQ-004 SHALL have port clk, input, 1 bit, sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit, reset; asynchronous and active-low.
REQ-006 SHALL have port start, input, 1 bit, begins one matrix operation.
REQ-007 SHALL have port transpose, input, 1 bit, feeds the input matrix transposed; sampled with start.
REQ-008 SHALL have port weights, input, N*N*DW bits, weight matrix W, row-major; element [r][c] at index (r*N+c).
REQ-009 SHALL have port inputs, input, N*N*DW bits, input matrix X, row-major.
REQ-010 SHALL have port c_flat, input, N*N*ACCW bits, signed array results, row-major.
REQ-011 SHALL have port a_data, output, N*DW bits, row operands to the array.
REQ-012 SHALL have port b_data, output, N*DW bits, column operands to the array.
REQ-013 SHALL have port clear, output, 1 bit, accumulator clear to the array.
REQ-014 SHALL have port out_valid, output, 1 bit, out_data holds a result.
REQ-015 SHALL have port out_ready, input, 1 bit, consumer accepts out_data.
REQ-016 SHALL have port out_data, output, DW bits, saturated result.
REQ-017 SHALL have port busy, output, 1 bit, high when the FSM is not in IDLE.
REQ-018 SHALL have port done, output, 1 bit, one-cycle pulse on completion.

Function
REQ-019 SHALL implement FSM states IDLE, FEED, DRAIN, OUT and CLR.
REQ-020 SHALL, in IDLE with start=1, capture weights, inputs and transpose into internal registers and enter FEED.
REQ-021 SHALL ignore start in every state other than IDLE.
REQ-022 SHALL stay in FEED for 2N-1 cycles, k=0..2N-2.
REQ-023 SHALL drive a_data lane i in FEED cycle k with W[i][k-i] when 0<=k-i<N, otherwise 0.
REQ-024 SHALL drive b_data lane j in FEED cycle k with X[k-j][j] when 0<=k-j<N, otherwise 0; with transpose=1, SHALL use X[j][k-j] instead.
REQ-025 SHALL drive a_data and b_data to 0 in every state other than FEED.
REQ-026 SHALL stay in DRAIN for N cycles, then enter OUT.
REQ-027 SHALL, in OUT, stream the N*N results in row-major order using the valid/ready handshake.
REQ-028 SHALL hold out_valid=1 and out_data stable until out_ready=1; a transfer occurs on a clock edge where both are 1.
REQ-029 SHALL saturate each result: c>2^(DW-1)-1 gives 2^(DW-1)-1; c<-2^(DW-1) gives -2^(DW-1); otherwise the low DW bits.
REQ-030 SHALL, after the N*N-th transfer, enter CLR for exactly one cycle with clear=1, then return to IDLE with done=1 on that IDLE-entry cycle.
REQ-031 SHALL hold out_valid=0 and out_data=0 outside OUT.
REQ-032 SHALL treat out_ready as don't-care outside OUT.

Reset
REQ-033 SHALL, on rst_n=0 in any state, immediately set state=IDLE, all counters=0, and a_data, b_data, clear, out_valid, out_data, busy and done to 0.
REQ-034 SHALL, after rst_n returns to 1, require a fresh start before any feed activity.

Configuration
REQ-035 SHALL use macro MMU_FEEDER_N_TRANSPOSE_EN to control transposed feeding.
REQ-036 SHALL, with MMU_FEEDER_N_TRANSPOSE_EN defined, implement the transposed feed per REQ-024.
REQ-037 SHALL, with MMU_FEEDER_N_TRANSPOSE_EN undefined, ignore the transpose port, omit its capture register, and always feed X[k-j][j].

Verification
REQ-038 SHALL cover: N=2, W=identity, X={1,2,3,4}, c_flat={1,2,3,4}, out_ready=1 -> FEED lasts 3 cycles, DRAIN 2 cycles; out_data sequence 1,2,3,4; clear for 1 cycle; done pulses once.
REQ-039 SHALL cover: c_flat={300,-200,127,-128} -> out_data sequence 127,-128,127,-128.
REQ-040 SHALL cover: out_ready held low for 3 cycles at the second result -> out_data stays 2 with out_valid=1; the stream resumes with no loss or duplication.
REQ-041 SHALL cover: MMU_FEEDER_N_TRANSPOSE_EN defined, transpose=1, X={1,2,3,4} -> FEED cycle 1 b_data lane0=2 and lane1=3 (lane0=3 and lane1=2 without transpose).
REQ-042 SHALL cover: rst_n pulsed low during FEED cycle 1 -> all outputs 0 asynchronously; no clear or done follows; the next start runs a full sequence.
REQ-043 SHALL cover: start re-asserted during DRAIN, and weights changed during FEED -> both ignored; fed values equal the values captured at the original start.

Source files
------------

// File: rtl/mmu_feeder_n.sv
// Operand feeder and result streamer for an N x N systolic matrix unit.
// Optional transposed input feed is enabled by defining MMU_FEEDER_N_TRANSPOSE_EN.
module mmu_feeder_n #(
  parameter int N    = 2,
  parameter int DW   = 8,
  parameter int ACCW = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  transpose,
  input  logic [N*N*DW-1:0]     weights,
  input  logic [N*N*DW-1:0]     inputs,
  input  logic [N*N*ACCW-1:0]   c_flat,
  output logic [N*DW-1:0]       a_data,
  output logic [N*DW-1:0]       b_data,
  output logic                  clear,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DW-1:0]         out_data,
  output logic                  busy,
  output logic                  done
);

  localparam int CW = $clog2(N*N) + 1;
  localparam logic [CW-1:0] FEED_LAST  = CW'(2*N-2);
  localparam logic [CW-1:0] DRAIN_LAST = CW'(N-1);
  localparam logic [CW-1:0] OUT_LAST   = CW'(N*N-1);
  localparam logic signed [ACCW-1:0] SAT_MAX = {{(ACCW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACCW-1:0] SAT_MIN = {{(ACCW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, FEED, DRAIN, OUT, CLR} state_t;

  state_t                 state, state_nx;
  logic [CW-1:0]          cnt, cnt_nx;
  logic [N*N*DW-1:0]      w_q, x_q;
  logic                   done_q;
  logic                   capture;
  logic signed [ACCW-1:0] c_sel;
  int                     d;

`ifdef MMU_FEEDER_N_TRANSPOSE_EN
  logic tr_q;
`else
  logic unused_transpose;
  assign unused_transpose = transpose;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      w_q    <= '0;
      x_q    <= '0;
      done_q <= 1'b0;
`ifdef MMU_FEEDER_N_TRANSPOSE_EN
      tr_q   <= 1'b0;
`endif
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      done_q <= (state == CLR);
      if (capture) begin
        w_q <= weights;
        x_q <= inputs;
`ifdef MMU_FEEDER_N_TRANSPOSE_EN
        tr_q <= transpose;
`endif
      end
    end
  end

  // cnt is the FEED cycle index k, the DRAIN cycle, or the OUT result index
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    capture  = 1'b0;
    case (state)
      IDLE: if (start) begin
        state_nx = FEED;
        cnt_nx   = '0;
        capture  = 1'b1;
      end
      FEED: if (cnt == FEED_LAST) begin
        state_nx = DRAIN;
        cnt_nx   = '0;
      end else begin
        cnt_nx = cnt + 1'b1;
      end
      DRAIN: if (cnt == DRAIN_LAST) begin
        state_nx = OUT;
        cnt_nx   = '0;
      end else begin
        cnt_nx = cnt + 1'b1;
      end
      OUT: if (out_ready) begin
        if (cnt == OUT_LAST) begin
          state_nx = CLR;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      CLR:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Skewed feed: lane i carries element (k - i) of its row/column, zero outside the window
  always_comb begin
    a_data = '0;
    b_data = '0;
    d      = 0;
    if (state == FEED) begin
      for (int unsigned i = 0; i < N; i++) begin
        d = int'(cnt) - int'(i);
        if (d >= 0 && d < N) begin
          a_data[i*DW +: DW] = w_q[(int'(i)*N + d)*DW +: DW];
`ifdef MMU_FEEDER_N_TRANSPOSE_EN
          if (tr_q)
            b_data[i*DW +: DW] = x_q[(int'(i)*N + d)*DW +: DW];
          else
            b_data[i*DW +: DW] = x_q[(d*N + int'(i))*DW +: DW];
`else
          b_data[i*DW +: DW] = x_q[(d*N + int'(i))*DW +: DW];
`endif
        end
      end
    end
  end

  always_comb begin
    c_sel     = '0;
    out_valid = 1'b0;
    out_data  = '0;
    if (state == OUT) begin
      c_sel     = c_flat[int'(cnt)*ACCW +: ACCW];
      out_valid = 1'b1;
      if (c_sel > SAT_MAX)
        out_data = SAT_MAX[DW-1:0];
      else if (c_sel < SAT_MIN)
        out_data = SAT_MIN[DW-1:0];
      else
        out_data = c_sel[DW-1:0];
    end
    clear = (state == CLR);
    busy  = (state != IDLE);
    done  = done_q;
  end

endmodule

// File: tb/tb_mmu_feeder_n.sv
// Randomized self-checking bench for mmu_feeder_n against a queue-based stream model.
module tb_mmu_feeder_n;

  localparam int N    = 2;
  localparam int DW   = 8;
  localparam int ACCW = 16;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                start;
  logic                transpose;
  logic [N*N*DW-1:0]   weights;
  logic [N*N*DW-1:0]   inputs;
  logic [N*N*ACCW-1:0] c_flat;
  logic [N*DW-1:0]     a_data;
  logic [N*DW-1:0]     b_data;
  logic                clear;
  logic                out_valid;
  logic                out_ready;
  logic [DW-1:0]       out_data;
  logic                busy;
  logic                done;

  int checks = 0;
  int errors = 0;

  int wm [N][N];
  int xm [N][N];
  int cv [N*N];
  bit tr_m;

  mmu_feeder_n #(.N(N), .DW(DW), .ACCW(ACCW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .transpose (transpose),
    .weights   (weights),
    .inputs    (inputs),
    .c_flat    (c_flat),
    .a_data    (a_data),
    .b_data    (b_data),
    .clear     (clear),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic bit eff_tr();
`ifdef MMU_FEEDER_N_TRANSPOSE_EN
    return tr_m;
`else
    return 1'b0;
`endif
  endfunction

  // Each lane's stream: lane-index leading zeros, the N operands, then trailing zeros
  function automatic logic [N*DW-1:0] skew(input bit is_a, input int k);
    logic [N*DW-1:0] r;
    int v;
    r = '0;
    for (int lane = 0; lane < N; lane++) begin
      int q[$];
      for (int z = 0; z < lane; z++) q.push_back(0);
      for (int e = 0; e < N; e++) begin
        if (is_a)        q.push_back(wm[lane][e]);
        else if (eff_tr()) q.push_back(xm[lane][e]);
        else             q.push_back(xm[e][lane]);
      end
      while (q.size() < 2*N-1) q.push_back(0);
      v = q[k];
      r[lane*DW +: DW] = v[DW-1:0];
    end
    return r;
  endfunction

  function automatic logic [DW-1:0] sat(input int c);
    int r;
    if (c > 127)       r = 127;
    else if (c < -128) r = -128;
    else               r = c;
    return r[DW-1:0];
  endfunction

  task automatic pack_all();
    int v;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        v = wm[r][c]; weights[(r*N+c)*DW +: DW] = v[DW-1:0];
        v = xm[r][c]; inputs[(r*N+c)*DW +: DW]  = v[DW-1:0];
      end
    for (int i = 0; i < N*N; i++) begin
      v = cv[i];
      c_flat[i*ACCW +: ACCW] = v[ACCW-1:0];
    end
    transpose = tr_m;
  endtask

  task automatic randomize_op();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        wm[r][c] = int'($urandom_range(0, 255));
        xm[r][c] = int'($urandom_range(0, 255));
      end
    for (int i = 0; i < N*N; i++) cv[i] = int'($urandom_range(0, 800)) - 400;
    tr_m = 1'($urandom_range(0, 1));
  endtask

  // ready_mode: 0 always ready, 1 random ready, 2 three-cycle stall at the second result
  task automatic run_op(input int ready_mode, input bit disturb, input bit chk_k1);
    int idx, cyc, stall;
    bit rdy;
    logic [DW-1:0] e8;
    pack_all();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 2*N-1; k++) begin
      check("a_feed", a_data, skew(1'b1, k));
      check("b_feed", b_data, skew(1'b0, k));
      check("busy_feed", busy, 1);
      check("valid_feed", out_valid, 0);
      check("clear_feed", clear, 0);
      if (chk_k1 && k == 1) begin
        e8 = eff_tr() ? 8'd2 : 8'd3;
        check("b_k1_lane0", b_data[DW-1:0], e8);
        e8 = eff_tr() ? 8'd3 : 8'd2;
        check("b_k1_lane1", b_data[2*DW-1:DW], e8);
      end
      if (disturb && k == 0) begin
        weights = {$urandom, $urandom};
        inputs  = {$urandom, $urandom};
        start   = 1'b1;
      end
      @(negedge clk);
    end
    for (int dc = 0; dc < N; dc++) begin
      check("a_drain", a_data, 0);
      check("b_drain", b_data, 0);
      check("busy_drain", busy, 1);
      check("valid_drain", out_valid, 0);
      @(negedge clk);
    end
    start = 1'b0;
    idx = 0; cyc = 0; stall = 0;
    while (idx < N*N && cyc < 100) begin
      check("out_valid", out_valid, 1);
      e8 = sat(cv[idx]);
      check("out_data", out_data, e8);
      check("a_out", a_data, 0);
      check("clear_out", clear, 0);
      if (ready_mode == 0)      rdy = 1'b1;
      else if (ready_mode == 1) rdy = 1'($urandom_range(0, 1));
      else if (idx == 1 && stall < 3) begin rdy = 1'b0; stall++; end
      else                      rdy = 1'b1;
      out_ready = rdy;
      if (rdy) idx++;
      cyc++;
      @(negedge clk);
    end
    if (idx < N*N) check("out_timeout", 0, 1);
    out_ready = 1'($urandom_range(0, 1));
    check("clear_clr", clear, 1);
    check("valid_clr", out_valid, 0);
    check("odata_clr", out_data, 0);
    check("done_clr", done, 0);
    check("busy_clr", busy, 1);
    @(negedge clk);
    check("done_pulse", done, 1);
    check("busy_idle", busy, 0);
    check("clear_idle", clear, 0);
    @(negedge clk);
    check("done_once", done, 0);
    check("a_idle", a_data, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; transpose = 1'b0; out_ready = 1'b0;
    weights = '0; inputs = '0; c_flat = '0;
    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_clear", clear, 0);
    check("rst_valid", out_valid, 0);
    check("rst_a", a_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // identity weights, small results, always ready
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        wm[r][c] = (r == c) ? 1 : 0;
        xm[r][c] = r*N + c + 1;
      end
    for (int i = 0; i < N*N; i++) cv[i] = i + 1;
    tr_m = 1'b0;
    run_op(0, 1'b0, 1'b1);

    // saturation corners
    cv[0] = 300; cv[1] = -200; cv[2] = 127; cv[3] = -128;
    run_op(0, 1'b0, 1'b0);

    // back-pressure at the second result
    for (int i = 0; i < N*N; i++) cv[i] = i + 1;
    run_op(2, 1'b0, 1'b0);

    // transpose request on the directed matrix
    tr_m = 1'b1;
    run_op(0, 1'b0, 1'b1);

    // asynchronous reset during FEED cycle 1
    tr_m = 1'b0;
    pack_all();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_a", a_data, 0);
    check("arst_b", b_data, 0);
    check("arst_busy", busy, 0);
    check("arst_valid", out_valid, 0);
    check("arst_clear", clear, 0);
    check("arst_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("post_rst_busy", busy, 0);
      check("post_rst_clear", clear, 0);
      check("post_rst_done", done, 0);
      check("post_rst_a", a_data, 0);
    end
    run_op(0, 1'b0, 1'b1);

    // start during DRAIN and operand changes during FEED are ignored
    randomize_op();
    run_op(0, 1'b1, 1'b0);

    for (int t = 0; t < 20; t++) begin
      randomize_op();
      run_op(1, 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
